// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: assembles HEAD/CMD[/DATA x4] UART byte frames into a held SDRAM command.
// Define UART_CMD_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module uart_cmd_ctrl #(
   parameter logic [7:0]  HEAD        = 8'h55,
   parameter logic [7:0]  CMD_WR      = 8'hAA,
   parameter logic [7:0]  CMD_RD      = 8'hA5,
   parameter int unsigned TIMEOUT_END = 52080
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        po_flag,
   input  logic        cmd_ack,
   output logic        cmd_req,
   output logic        cmd_wr,
   output logic [31:0] cmd_data,
   output logic        err_flag
);

   localparam logic [15:0] GAP_LAST = 16'(TIMEOUT_END - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CMD   = 3'd1,
      S_DATA  = 3'd2,
      S_CHK   = 3'd3,
      S_ISSUE = 3'd4
   } state_t;

   // State entered once the command/payload bytes are complete.
`ifdef UART_CMD_CHKSUM_EN
   localparam state_t S_PAYLOAD_DONE = S_CHK;
`else
   localparam state_t S_PAYLOAD_DONE = S_ISSUE;
`endif

   state_t      r_state;
   state_t      w_next;
   logic        w_err;
   logic        w_in_frame;
   logic        w_timeout;

   logic        r_cmd_req;
   logic        r_cmd_wr;
   logic [31:0] r_cmd_data;
   logic        r_err;
   logic [1:0]  r_cnt;
   logic [15:0] r_gap;
`ifdef UART_CMD_CHKSUM_EN
   logic [7:0]  r_chk;
`endif

   assign w_in_frame = (r_state == S_CMD) || (r_state == S_DATA) || (r_state == S_CHK);
   // A byte arriving on the terminal cycle takes priority over the timeout.
   assign w_timeout  = w_in_frame && !po_flag && (r_gap == GAP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (po_flag && rx_data == HEAD) w_next = S_CMD;
         end
         S_CMD: begin
            if (po_flag) begin
               if (rx_data == CMD_WR)      w_next = S_DATA;
               else if (rx_data == CMD_RD) w_next = S_PAYLOAD_DONE;
               else begin
                  w_next = S_IDLE;
                  w_err  = 1'b1;
               end
            end else if (w_timeout) begin
               w_next = S_IDLE;
               w_err  = 1'b1;
            end
         end
         S_DATA: begin
            if (po_flag) begin
               if (r_cnt == 2'd3) w_next = S_PAYLOAD_DONE;
            end else if (w_timeout) begin
               w_next = S_IDLE;
               w_err  = 1'b1;
            end
         end
`ifdef UART_CMD_CHKSUM_EN
         S_CHK: begin
            if (po_flag) begin
               if (rx_data == r_chk) w_next = S_ISSUE;
               else begin
                  w_next = S_IDLE;
                  w_err  = 1'b1;
               end
            end else if (w_timeout) begin
               w_next = S_IDLE;
               w_err  = 1'b1;
            end
         end
`endif
         S_ISSUE: begin
            if (cmd_ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_req  <= 1'b0;
         r_cmd_wr   <= 1'b0;
         r_cmd_data <= 32'd0;
         r_err      <= 1'b0;
         r_cnt      <= 2'd0;
         r_gap      <= 16'd0;
`ifdef UART_CMD_CHKSUM_EN
         r_chk      <= 8'd0;
`endif
      end else begin
         r_err     <= w_err;
         r_cmd_req <= (w_next == S_ISSUE);
         if (r_state == S_CMD && po_flag) begin
            if (rx_data == CMD_WR) begin
               r_cmd_wr <= 1'b1;
               r_cnt    <= 2'd0;
            end else if (rx_data == CMD_RD) begin
               r_cmd_wr <= 1'b0;
            end
         end
         if (r_state == S_DATA && po_flag) begin
            r_cmd_data <= {r_cmd_data[23:0], rx_data};
            r_cnt      <= r_cnt + 2'd1;
         end
         // Gap counter idles at zero outside a frame, so entry to CMD starts clean.
         if (w_in_frame && !po_flag) r_gap <= r_gap + 16'd1;
         else                        r_gap <= 16'd0;
`ifdef UART_CMD_CHKSUM_EN
         if (r_state == S_CMD && po_flag)       r_chk <= rx_data;
         else if (r_state == S_DATA && po_flag) r_chk <= r_chk ^ rx_data;
`endif
      end
   end

   assign cmd_req  = r_cmd_req;
   assign cmd_wr   = r_cmd_wr;
   assign cmd_data = r_cmd_data;
   assign err_flag = r_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed frames into uart_cmd_ctrl, expected commands/errors queued and
// checked by an independent output monitor (honours UART_CMD_CHKSUM_EN).
module tb_uart_cmd_ctrl;
   localparam int TE = 20;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        po_flag;
   logic        cmd_ack;
   logic        cmd_req;
   logic        cmd_wr;
   logic [31:0] cmd_data;
   logic        err_flag;

   typedef struct {
      bit          is_err;
      bit          lat;
      bit          wr;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   last_po = -1;
   bit   prev_req = 1'b0;
   bit   prev_err = 1'b0;
   logic [31:0] cap_data;
   logic        cap_wr;

   uart_cmd_ctrl #(.TIMEOUT_END(TE)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .po_flag  (po_flag),
      .cmd_ack  (cmd_ack),
      .cmd_req  (cmd_req),
      .cmd_wr   (cmd_wr),
      .cmd_data (cmd_data),
      .err_flag (err_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (po_flag) last_po = cyc;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Output monitor: every err pulse and cmd_req rise must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (err_flag) begin
         check("err_one_cycle", {31'd0, prev_err}, 32'd0);
         if (!prev_err) begin
            if (q.size() == 0) check("unexpected_err", 32'd1, 32'd0);
            else begin
               e = q.pop_front();
               check("event_is_err", {31'd0, e.is_err}, 32'd1);
               if (e.lat) check("err_latency", cyc, last_po);
            end
         end
      end
      if (cmd_req && !prev_req) begin
         if (q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
         else begin
            e = q.pop_front();
            check("event_is_cmd", {31'd0, e.is_err}, 32'd0);
            check("cmd_wr", {31'd0, cmd_wr}, {31'd0, e.wr});
            check("cmd_data", cmd_data, e.data);
            if (e.lat) check("req_latency", cyc, last_po);
         end
         cap_data = cmd_data;
         cap_wr   = cmd_wr;
      end else if (cmd_req && prev_req) begin
         check("data_stable", cmd_data, cap_data);
         check("wr_stable", {31'd0, cmd_wr}, {31'd0, cap_wr});
      end
      prev_req = cmd_req;
      prev_err = err_flag;
   end

   function automatic logic [7:0] xsum(input logic [7:0] c, input logic [31:0] d);
      return c ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
   endfunction

   // Called at a negedge; the byte is sampled at the next posedge.
   task automatic send_byte(input logic [7:0] b, input int idle);
      rx_data = b;
      po_flag = 1'b1;
      @(negedge clk);
      po_flag = 1'b0;
      repeat (idle) @(negedge clk);
   endtask

   task automatic send_wr(input logic [31:0] d, input int idle);
      send_byte(8'h55, idle);
      send_byte(8'hAA, idle);
      send_byte(d[31:24], idle);
      send_byte(d[23:16], idle);
      send_byte(d[15:8], idle);
      send_byte(d[7:0], idle);
`ifdef UART_CMD_CHKSUM_EN
      send_byte(xsum(8'hAA, d), idle);
`endif
   endtask

   task automatic send_rd();
      send_byte(8'h55, 0);
      send_byte(8'hA5, 0);
`ifdef UART_CMD_CHKSUM_EN
      send_byte(8'hA5, 0);
`endif
   endtask

   task automatic expect_cmd(input bit wr, input logic [31:0] d);
      exp_t e;
      e.is_err = 1'b0; e.lat = 1'b1; e.wr = wr; e.data = d;
      q.push_back(e);
   endtask

   task automatic expect_err(input bit lat);
      exp_t e;
      e.is_err = 1'b1; e.lat = lat; e.wr = 1'b0; e.data = 32'd0;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 50 && !cmd_req; i++) @(negedge clk);
      check("req_seen", {31'd0, cmd_req}, 32'd1);
   endtask

   task automatic do_ack();
      wait_req();
      cmd_ack = 1'b1;
      @(negedge clk);
      cmd_ack = 1'b0;
      check("req_clear", {31'd0, cmd_req}, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"}, {31'd0, cmd_req}, 32'd0);
      check({tag, "_wr"}, {31'd0, cmd_wr}, 32'd0);
      check({tag, "_data"}, cmd_data, 32'd0);
      check({tag, "_err"}, {31'd0, err_flag}, 32'd0);
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, queue depth %0d", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      rx_data = 8'h00;
      po_flag = 1'b0;
      cmd_ack = 1'b0;
      idle(3);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // Write frame, held without ack, then acked.
      expect_cmd(1'b1, 32'h12345678);
      send_wr(32'h12345678, 0);
      idle(5);
      do_ack();
      check("data_retained", cmd_data, 32'h12345678);
      check("wr_retained", {31'd0, cmd_wr}, 32'd1);

      // Ack with nothing pending is ignored.
      cmd_ack = 1'b1;
      idle(1);
      cmd_ack = 1'b0;
      idle(3);

      // Read frame keeps the previous payload.
      expect_cmd(1'b0, 32'h12345678);
      send_rd();
      do_ack();

      // Bad command byte, then noise in IDLE.
      expect_err(1'b1);
      send_byte(8'h55, 0);
      send_byte(8'h3C, 0);
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'hAA, 3);

      // Gap of exactly TE idle cycles times out; the rest of the frame is ignored.
      expect_err(1'b0);
      send_byte(8'h55, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h12, TE);
      send_byte(8'h34, 0);
      send_byte(8'h56, 0);
      send_byte(8'h78, 0);
      send_byte(8'h79, 5);

      // Gap of TE-1 idle cycles lands on the terminal cycle: byte wins.
      expect_cmd(1'b1, 32'hDEADBEEF);
      send_wr(32'hDEADBEEF, TE - 1);
      wait_req();
      // Bytes arriving while a command is pending are dropped.
      send_wr(32'h01020304, 0);
      idle(3);
      do_ack();
      check("issue_drop_data", cmd_data, 32'hDEADBEEF);

      // Back-to-back write; a HEAD byte on the ack cycle is dropped.
      expect_cmd(1'b1, 32'hA1B2C3D4);
      send_wr(32'hA1B2C3D4, 0);
      wait_req();
      rx_data = 8'h55;
      po_flag = 1'b1;
      cmd_ack = 1'b1;
      @(negedge clk);
      po_flag = 1'b0;
      cmd_ack = 1'b0;
      check("ack_cycle_clear", {31'd0, cmd_req}, 32'd0);
      send_byte(8'hAA, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h00, 5);

      // Reset in the middle of DATA abandons the frame.
      send_byte(8'h55, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h11, 0);
      pulse_reset();
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, TE + 5);

      // Reset while a read is pending.
      expect_cmd(1'b0, 32'h00000000);
      send_rd();
      wait_req();
      pulse_reset();
      idle(TE + 5);

`ifdef UART_CMD_CHKSUM_EN
      expect_cmd(1'b1, 32'h01020304);
      send_byte(8'h55, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      send_byte(8'hAE, 0);
      do_ack();
      expect_err(1'b1);
      send_byte(8'h55, 0);
      send_byte(8'hAA, 0);
      send_byte(8'h05, 0);
      send_byte(8'h06, 0);
      send_byte(8'h07, 0);
      send_byte(8'h08, 0);
      send_byte(8'hAF, 10);
`endif

      idle(20);
      check("queue_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL provide parameter HEAD, default 8'h55, frame header byte.
REQ-002 SHALL provide parameter CMD_WR, default 8'hAA, write-command byte.
REQ-003 SHALL provide parameter CMD_RD, default 8'hA5, read-command byte.
REQ-004 SHALL provide parameter TIMEOUT_END, default 52080, max clk cycles between bytes of a frame.
REQ-005 SHALL provide port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL provide port rx_data  input  8  received byte, valid when po_flag=1.
REQ-008 SHALL provide port po_flag  input  1  one-cycle byte-valid pulse from UART receiver.
REQ-009 SHALL provide port cmd_ack  input  1  SDRAM-side acceptance of the pending command.
REQ-010 SHALL provide port cmd_req  output  1  command pending, level held until acked.
REQ-011 SHALL provide port cmd_wr  output  1  1=write, 0=read; valid while cmd_req=1.
REQ-012 SHALL provide port cmd_data  output  32  write payload; valid while cmd_req=1 and cmd_wr=1.
REQ-013 SHALL provide port err_flag  output  1  one-cycle pulse on discarded frame.

Function
REQ-014 SHALL implement FSM states IDLE, CMD, DATA, ISSUE, all outputs registered.
REQ-015 IDLE: po_flag with rx_data==HEAD -> CMD; any other byte ignored, no err_flag.
REQ-016 CMD: CMD_WR -> DATA, cmd_wr<=1, byte count cleared; CMD_RD -> ISSUE, cmd_wr<=0; other value -> IDLE plus err_flag pulse.
REQ-017 DATA: SHALL collect 4 bytes MSB-first (first byte -> cmd_data[31:24]) via shift-left-by-8; after 4th byte -> ISSUE.
REQ-018 cmd_req SHALL rise the cycle after the po_flag completing the frame and stay high until the cycle after cmd_ack=1.
REQ-019 ISSUE with cmd_ack=1 SHALL clear cmd_req and return to IDLE next cycle; cmd_ack while cmd_req=0 ignored.
REQ-020 cmd_data and cmd_wr SHALL be stable while cmd_req=1 and retain last value afterwards.
REQ-021 po_flag in ISSUE (including the cmd_ack cycle) SHALL be dropped silently.
REQ-022 Gap counter SHALL run in CMD and DATA, clear on every po_flag and on entry to CMD; reaching TIMEOUT_END-1 -> IDLE plus err_flag pulse.
REQ-023 po_flag on the timeout-terminal cycle SHALL win: byte processed, no timeout.
REQ-024 Gap counter width SHALL be 16 bits; no wrap possible below TIMEOUT_END.

Reset
REQ-025 rst_n=0 SHALL force state IDLE, cmd_req=0, cmd_wr=0, cmd_data=0, err_flag=0, all counters 0, immediately and regardless of clk.
REQ-026 Reset mid-frame or during ISSUE SHALL abandon the frame with no cmd_req or err_flag after release.

Configuration
REQ-027 Macro UART_CMD_CHKSUM_EN defined: one checksum byte SHALL follow the payload (write: after 4th data byte; read: after command byte), value = XOR of command and all data bytes; match -> ISSUE, mismatch -> IDLE plus err_flag, payload not issued.
REQ-028 Macro undefined: no checksum byte; transitions per REQ-016/017; checksum logic absent.

Verification
REQ-029 Without macro: bytes 55 AA 12 34 56 78 -> cmd_req=1 one cycle after last po_flag, cmd_wr=1, cmd_data=32'h12345678; held until cmd_ack.
REQ-030 Without macro: 55 A5 -> cmd_req=1, cmd_wr=0; cmd_ack held 1 cycle -> cmd_req=0 next cycle, state IDLE.
REQ-031 55 3C -> err_flag one-cycle pulse, no cmd_req; then 00 FF -> no response.
REQ-032 55 AA 12 then gap of TIMEOUT_END cycles -> err_flag pulse; following 34 56 78 79 ignored, no cmd_req.
REQ-033 With macro: 55 AA 01 02 03 04 AE -> issue 32'h01020304; same with checksum AF -> err_flag, no cmd_req.
REQ-034 rst_n low during DATA after 55 AA 11 -> all outputs 0; after release 22 33 44 produces nothing.
